arch_state: RTL
===============

ARCH_STATE -- requirements
Module: arch_state

Interface
REQ-001 SHALL have parameter CLEAR_GPR_ON_RST, default 1, meaning rst zeroes all 31 writable GPRs; 0 means rst leaves GPR contents unchanged.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state updates occur on it.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  exception flush from the control unit.
REQ-005 SHALL have port we  input  1  GPR write enable from the writeback latch.
REQ-006 SHALL have port waddr  input  5  GPR write address.
REQ-007 SHALL have port wdata  input  32  GPR write data.
REQ-008 SHALL have port whilo  input  1  HI/LO write enable.
REQ-009 SHALL have port hi_i  input  32  new HI value.
REQ-010 SHALL have port lo_i  input  32  new LO value.
REQ-011 SHALL have port LLbit_we  input  1  LLbit write enable.
REQ-012 SHALL have port LLbit_i  input  1  new LLbit value.
REQ-013 SHALL have ports re1, re2  input  1 each  read enables, decode stage.
REQ-014 SHALL have ports raddr1, raddr2  input  5 each  read addresses.
REQ-015 SHALL have ports rdata1, rdata2  output  32 each  combinational read data.
REQ-016 SHALL have ports hi_o, lo_o  output  32 each  stored HI and LO.
REQ-017 SHALL have port LLbit_o  output  1  stored LLbit.

Function
REQ-018 SHALL hold GPR1..GPR31 as 32-bit registers; GPR0 has no storage and reads 0.
REQ-019 SHALL write wdata into GPR[waddr] on the rising edge when we=1, rst=0 and waddr!=0; a write to address 0 is discarded.
REQ-020 SHALL drive rdataN = 0 when rst=1, reN=0 or raddrN=0, in that priority.
REQ-021 SHALL otherwise drive rdataN = wdata when we=1 and waddr==raddrN (same-cycle write bypass), else GPR[raddrN].
REQ-022 SHALL let both read ports address the same register, each receiving the same value.
REQ-023 SHALL load hi_i and lo_i together on the edge when whilo=1; HI/LO are not bypassed, and hi_o/lo_o change one cycle after the write.
REQ-024 SHALL set LLbit next edge by priority: flush=1 -> 0; else LLbit_we=1 -> LLbit_i; else hold.
REQ-025 SHALL NOT let flush block GPR or HI/LO writes presented in the same cycle, because the writeback latch has already been squashed upstream.
REQ-026 SHALL give rst priority over flush, we, whilo and LLbit_we.
REQ-027 SHALL have zero read latency and a one-edge write latency, with no stall or handshake outputs.

Reset
REQ-028 SHALL, on any edge with rst=1, clear HI, LO and LLbit to 0, and clear GPR1..31 to 0 when CLEAR_GPR_ON_RST=1.
REQ-029 SHALL discard any write presented in a reset cycle; a reset asserted mid-sequence loses only that cycle's writes.

Structure
REQ-030 SHALL take RegBus, RegAddrBus, RstEnable, WriteEnable, ReadEnable, ZeroWord and NOPRegAddr from the shared defines.v.
REQ-031 SHALL place LLbit storage in one sub-module, llbit_reg, with ports clk, rst, flush, we, LLbit_i and LLbit_o.
REQ-032 SHALL implement the GPR array and HI/LO inline in arch_state.

Verification
REQ-033 SHALL cover: we=1, waddr=5, wdata=0xDEADBEEF, re1=1, raddr1=5 in the same cycle -> rdata1=0xDEADBEEF that cycle and from storage on the next cycle.
REQ-034 SHALL cover: we=1, waddr=0, wdata=0xFFFFFFFF, then re1=re2=1, raddr=0 -> rdata1=rdata2=0 in both the write cycle and the following cycle.
REQ-035 SHALL cover: whilo=1, hi_i=0x12345678, lo_i=0x9ABCDEF0 -> hi_o and lo_o show these values exactly one edge later and hold while whilo=0.
REQ-036 SHALL cover: LLbit_we=1, LLbit_i=1 -> LLbit_o=1; then flush=1 together with LLbit_we=1, LLbit_i=1 -> LLbit_o=0.
REQ-037 SHALL cover: GPR3=0x55 written, then rst=1 together with we=1, waddr=3, wdata=0xAA -> after the edge GPR3 reads 0 (CLEAR_GPR_ON_RST=1) or 0x55 (=0), with HI=LO=LLbit=0.
REQ-038 SHALL cover: re1=0 with raddr1=3 holding 0x77 -> rdata1=0.

Source files
------------

// File: rtl/arch_state_pkg.sv
// rtl/arch_state_pkg.sv - shared register-file widths, constants and read-port helper
//
// Purpose: common definitions for the architectural state block (GPRs, HI/LO, LLbit).
// Contents:
//   REG_W / REG_ADDR_W / REG_NUM  register width, address width, register count
//   reg_t / reg_addr_t             data and address types
//   ZERO_WORD / NOP_REG_ADDR       zero data word and the hard-wired zero register address
//   RST_ENABLE / WRITE_ENABLE / READ_ENABLE  active levels of the control strobes
//   read_port()                    one GPR read port including reset gating and write bypass
package arch_state_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef logic [REG_W-1:0]      reg_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_t      ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  // Priority: reset, disabled port, register 0, same-cycle writeback, stored value.
  // The bypass lets decode see a value that writeback is committing on this edge.
  function automatic reg_t read_port(
    input logic      rst,
    input logic      re,
    input reg_addr_t raddr,
    input logic      we,
    input reg_addr_t waddr,
    input reg_t      wdata,
    input reg_t      stored
  );
    if (rst == RST_ENABLE) begin
      return ZERO_WORD;
    end else if (re != READ_ENABLE) begin
      return ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      return ZERO_WORD;
    end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

endpackage

// File: rtl/llbit_reg.sv
// rtl/llbit_reg.sv - load-linked flag register
//
// Purpose: holds the LL/SC link bit. A flush (exception) breaks the link even if a
// write is presented in the same cycle; reset wins over everything.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, clears the bit
//   flush    in   exception flush, clears the bit
//   we       in   write enable
//   LLbit_i  in   new link bit value
//   LLbit_o  out  stored link bit
module llbit_reg
  import arch_state_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic we,
  input  logic LLbit_i,
  output logic LLbit_o
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      LLbit_o <= 1'b0;
    end else if (flush) begin
      LLbit_o <= 1'b0;
    end else if (we == WRITE_ENABLE) begin
      LLbit_o <= LLbit_i;
    end
  end

endmodule

// File: rtl/arch_state.sv
// rtl/arch_state.sv - architectural state: 31 GPRs, HI/LO and LLbit
//
// Purpose: MIPS-style register file with two combinational read ports (with
// writeback bypass), a HI/LO pair loaded together, and the LL/SC link bit.
// Parameter:
//   CLEAR_GPR_ON_RST  1: reset zeroes GPR1..31; 0: reset leaves GPR contents intact
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   flush                    exception flush (affects only LLbit)
//   we, waddr, wdata         GPR write port from the writeback latch
//   whilo, hi_i, lo_i        HI/LO write port
//   LLbit_we, LLbit_i        LLbit write port
//   re1/raddr1/rdata1,
//   re2/raddr2/rdata2        decode-stage read ports, zero latency
//   hi_o, lo_o, LLbit_o      stored HI, LO and LLbit
module arch_state
  import arch_state_pkg::*;
#(
  parameter bit CLEAR_GPR_ON_RST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_t      wdata,
  input  logic      whilo,
  input  reg_t      hi_i,
  input  reg_t      lo_i,
  input  logic      LLbit_we,
  input  logic      LLbit_i,
  input  logic      re1,
  input  reg_addr_t raddr1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_t      rdata1,
  output reg_t      rdata2,
  output reg_t      hi_o,
  output reg_t      lo_o,
  output logic      LLbit_o
);

  // Register 0 is hard-wired to zero, so storage starts at index 1.
  reg_t gpr [1:REG_NUM-1];

  reg_t stored1;
  reg_t stored2;

  // Flush does not gate these writes: the writeback latch feeding them has
  // already been squashed upstream when the exception was taken.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      if (CLEAR_GPR_ON_RST) begin
        for (int i = 1; i < REG_NUM; i++) begin
          gpr[i] <= ZERO_WORD;
        end
      end
    end else if ((we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR)) begin
      gpr[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_o <= ZERO_WORD;
      lo_o <= ZERO_WORD;
    end else if (whilo == WRITE_ENABLE) begin
      hi_o <= hi_i;
      lo_o <= lo_i;
    end
  end

  // Address 0 has no storage; its stored value is masked off in read_port().
  always_comb begin
    stored1 = ZERO_WORD;
    stored2 = ZERO_WORD;
    if (raddr1 != NOP_REG_ADDR) stored1 = gpr[raddr1];
    if (raddr2 != NOP_REG_ADDR) stored2 = gpr[raddr2];
  end

  assign rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, stored1);
  assign rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, stored2);

  llbit_reg u_llbit_reg (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .we      (LLbit_we),
    .LLbit_i (LLbit_i),
    .LLbit_o (LLbit_o)
  );

endmodule
